// File: rtl/game_core_nxn.sv
// game_core_nxn: N x N in-a-row game engine.
//   Two players alternate moves on an N x N board. A move is written in
//   WAIT_MOVE, then CHECK spends four cycles scanning the four line
//   directions through the new cell (one direction per cycle). The game ends
//   in DONE_WIN or DONE_DRAW until newGame restarts it.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | one-cycle load of the starting player
//   WAIT_MOVE | waiting for a legal move request
//   CHECK     | four cycles: horizontal, vertical, diagonal, anti-diagonal
//   DONE_WIN  | line completed, winner holds the mover
//   DONE_DRAW | board full with no line
//
// Ports:
//   ph1            in   clock, rising edge
//   reset_n        in   synchronous active-low reset
//   isPlayer1Start in   1: player 1 moves first, 0: player 2 moves first
//   playerWrite    in   move request strobe
//   playerInput    in   requested cell, row*N+col
//   newGame        in   restart request, honoured in DONE states only
//   gBoard         out  2 bits per cell: 00 empty, 01 player 1, 10 player 2
//   gameState      out  FSM state encoding
//   gameIsDone     out  high in DONE_WIN / DONE_DRAW
//   winner         out  00 none/draw, 01 player 1, 10 player 2
//   currentPlayer  out  player to move (00 in IDLE)
//   moveAccept     out  one-cycle pulse, move written
//   moveReject     out  one-cycle pulse, move refused
module game_core_nxn #(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic                      ph1,
    input  logic                      reset_n,
    input  logic                      isPlayer1Start,
    input  logic                      playerWrite,
    input  logic [$clog2(N*N)-1:0]    playerInput,
    input  logic                      newGame,
    output logic [2*N*N-1:0]          gBoard,
    output logic [2:0]                gameState,
    output logic                      gameIsDone,
    output logic [1:0]                winner,
    output logic [1:0]                currentPlayer,
    output logic                      moveAccept,
    output logic                      moveReject
);
    localparam int W     = $clog2(N*N);
    localparam int CELLS = N * N;
    localparam int MW    = $clog2(CELLS + 1);
    localparam logic [MW-1:0] CELLS_M = MW'(CELLS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_CHECK = 3'd2,
        S_WIN   = 3'd3,
        S_DRAW  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_cell [CELLS];
    logic [1:0]     r_player;
    logic [1:0]     r_winner;
    logic [MW-1:0]  r_moves;
    logic [W-1:0]   r_row;
    logic [W-1:0]   r_col;
    logic [1:0]     r_dir;
    logic           r_win;
    logic           r_accept;
    logic           r_reject;

    logic           w_in_range;
    logic           w_cell_empty;
    logic           w_accept;
    logic           w_dir_win;
    logic           w_run;
    logic [W-1:0]   w_pos;
    int             w_dr;
    int             w_dc;
    int             w_rr;
    int             w_cc;
    int             w_count;

    assign w_in_range   = 32'(playerInput) < 32'(CELLS);
    assign w_cell_empty = w_in_range && (r_cell[playerInput] == 2'b00);
    assign w_accept     = (r_state == S_WAIT) && playerWrite && w_cell_empty;

    // Run length through the latched cell along the direction selected by
    // r_dir, walking outward on both sides and stopping at the first
    // non-matching cell or at the board edge (rows never wrap).
    always_comb begin
        w_dr    = 0;
        w_dc    = 1;
        w_rr    = 0;
        w_cc    = 0;
        w_pos   = '0;
        w_run   = 1'b0;
        w_count = 1;
        case (r_dir)
            2'd1:    begin w_dr = 1; w_dc = 0;  end
            2'd2:    begin w_dr = 1; w_dc = 1;  end
            2'd3:    begin w_dr = 1; w_dc = -1; end
            default: begin w_dr = 0; w_dc = 1;  end
        endcase
        for (int side = 0; side < 2; side++) begin
            w_run = 1'b1;
            for (int s = 1; s < K; s++) begin
                w_rr = int'(r_row) + ((side == 0) ? s * w_dr : -(s * w_dr));
                w_cc = int'(r_col) + ((side == 0) ? s * w_dc : -(s * w_dc));
                if (w_rr >= 0 && w_rr < N && w_cc >= 0 && w_cc < N) begin
                    w_pos = W'(w_rr * N + w_cc);
                    if (w_run && r_cell[w_pos] == r_player) begin
                        w_count = w_count + 1;
                    end else begin
                        w_run = 1'b0;
                    end
                end else begin
                    w_run = 1'b0;
                end
            end
        end
        w_dir_win = (w_count >= K);
    end

    always_ff @(posedge ph1) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_WAIT;
            S_WAIT:  if (w_accept) w_next = S_CHECK;
            S_CHECK: begin
                if (r_dir == 2'd3) begin
                    if (r_win || w_dir_win)     w_next = S_WIN;
                    else if (r_moves == CELLS_M) w_next = S_DRAW;
                    else                         w_next = S_WAIT;
                end
            end
            S_WIN, S_DRAW: if (newGame) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ph1) begin
        if (!reset_n) begin
            for (int i = 0; i < CELLS; i++) r_cell[i] <= 2'b00;
            r_player <= 2'b00;
            r_winner <= 2'b00;
            r_moves  <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_dir    <= 2'd0;
            r_win    <= 1'b0;
            r_accept <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_accept <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_player <= isPlayer1Start ? 2'b01 : 2'b10;
                end
                S_WAIT: begin
                    if (w_accept) begin
                        r_cell[playerInput] <= r_player;
                        r_accept <= 1'b1;
                        r_moves  <= r_moves + MW'(1);
                        r_row    <= W'(32'(playerInput) / N);
                        r_col    <= W'(32'(playerInput) % N);
                        r_dir    <= 2'd0;
                        r_win    <= 1'b0;
                    end else if (playerWrite) begin
                        r_reject <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (r_dir != 2'd3) begin
                        r_win <= r_win | w_dir_win;
                        r_dir <= r_dir + 2'd1;
                    end else if (r_win || w_dir_win) begin
                        r_winner <= r_player;
                    end else if (r_moves != CELLS_M) begin
                        r_player <= (r_player == 2'b01) ? 2'b10 : 2'b01;
                    end
                end
                S_WIN, S_DRAW: begin
                    if (newGame) begin
                        for (int i = 0; i < CELLS; i++) r_cell[i] <= 2'b00;
                        r_moves  <= '0;
                        r_winner <= 2'b00;
                        r_player <= 2'b00;
                        r_win    <= 1'b0;
                        r_dir    <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < CELLS; gi++) begin : g_pack
        assign gBoard[2*gi +: 2] = r_cell[gi];
    end

    always_comb begin
        gameState     = r_state;
        gameIsDone    = (r_state == S_WIN) || (r_state == S_DRAW);
        winner        = r_winner;
        currentPlayer = r_player;
        moveAccept    = r_accept;
        moveReject    = r_reject;
    end

endmodule

// File: tb/tb_game_core_nxn.sv
// tb_game_core_nxn: directed and random games against a 3x3 (K=3) and a
// 5x5 (K=4) instance. The reference model keeps the board as an array and
// looks for a winning line by scanning every line on the whole board.
module tb_game_core_nxn;
    logic        ph1 = 1'b0;
    logic        reset_n = 1'b0;
    logic        isP1 = 1'b0;
    logic        pw3 = 1'b0, pw5 = 1'b0, ng3 = 1'b0, ng5 = 1'b0;
    logic [3:0]  pi3 = '0;
    logic [4:0]  pi5 = '0;
    logic [17:0] g3;
    logic [49:0] g5;
    logic [2:0]  gs3, gs5;
    logic        done3, done5, acc3, acc5, rej3, rej5;
    logic [1:0]  win3, win5, cp3, cp5;

    int n_cmp = 0;
    int n_fail = 0;
    int sel = 0;

    int         mN, mK, mmoves;
    logic [1:0] mb [64];
    logic [1:0] mp;
    bit         mdone;
    int         m_exp_state;
    logic [1:0] m_exp_win;

    always #5 ph1 = ~ph1;

    game_core_nxn #(.N(3), .K(3)) dut3 (
        .ph1(ph1), .reset_n(reset_n), .isPlayer1Start(isP1), .playerWrite(pw3),
        .playerInput(pi3), .newGame(ng3), .gBoard(g3), .gameState(gs3),
        .gameIsDone(done3), .winner(win3), .currentPlayer(cp3),
        .moveAccept(acc3), .moveReject(rej3));

    game_core_nxn #(.N(5), .K(4)) dut5 (
        .ph1(ph1), .reset_n(reset_n), .isPlayer1Start(isP1), .playerWrite(pw5),
        .playerInput(pi5), .newGame(ng5), .gBoard(g5), .gameState(gs5),
        .gameIsDone(done5), .winner(win5), .currentPlayer(cp5),
        .moveAccept(acc5), .moveReject(rej5));

    function automatic logic [63:0] o_board(); return (sel != 0) ? 64'(g5) : 64'(g3); endfunction
    function automatic logic [63:0] o_state(); return (sel != 0) ? 64'(gs5) : 64'(gs3); endfunction
    function automatic logic [63:0] o_done();  return (sel != 0) ? 64'(done5) : 64'(done3); endfunction
    function automatic logic [63:0] o_win();   return (sel != 0) ? 64'(win5) : 64'(win3); endfunction
    function automatic logic [63:0] o_cp();    return (sel != 0) ? 64'(cp5) : 64'(cp3); endfunction
    function automatic logic [63:0] o_acc();   return (sel != 0) ? 64'(acc5) : 64'(acc3); endfunction
    function automatic logic [63:0] o_rej();   return (sel != 0) ? 64'(rej5) : 64'(rej3); endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    function automatic logic [63:0] exp_board();
        logic [63:0] b = '0;
        for (int i = 0; i < mN * mN; i++) b[2*i +: 2] = mb[i];
        return b;
    endfunction

    // Any complete K-long line of player p anywhere on the board.
    function automatic bit has_line(input logic [1:0] p);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        for (int r = 0; r < mN; r++)
            for (int c = 0; c < mN; c++)
                for (int d = 0; d < 4; d++) begin
                    bit ok = 1'b1;
                    for (int s = 0; s < mK; s++) begin
                        int rr = r + s * dr[d];
                        int cc = c + s * dc[d];
                        if (rr < 0 || rr >= mN || cc < 0 || cc >= mN) ok = 1'b0;
                        else if (mb[rr * mN + cc] != p) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 64; i++) mb[i] = 2'b00;
        mmoves = 0;
        mdone = 1'b0;
        mp = isP1 ? 2'b01 : 2'b10;
    endtask

    task automatic set_write(input bit v, input int idx);
        if (sel != 0) begin pw5 = v; pi5 = 5'(idx); end
        else begin pw3 = v; pi3 = 4'(idx); end
    endtask

    task automatic set_ng(input bit v);
        if (sel != 0) ng5 = v; else ng3 = v;
    endtask

    task automatic reset_all(input bit p1start);
        reset_n = 1'b0; isP1 = p1start;
        pw3 = 1'b0; pw5 = 1'b0; ng3 = 1'b0; ng5 = 1'b0;
        tick(); tick();
        chk("rst_state3", 64'(gs3), 64'd0);
        chk("rst_board3", 64'(g3), 64'd0);
        chk("rst_misc3", 64'({done3, win3, cp3, acc3, rej3}), 64'd0);
        chk("rst_state5", 64'(gs5), 64'd0);
        chk("rst_board5", 64'(g5), 64'd0);
        chk("rst_misc5", 64'({done5, win5, cp5, acc5, rej5}), 64'd0);
        reset_n = 1'b1;
        tick(); tick();
        chk("rel_state3", 64'(gs3), 64'd1);
        chk("rel_cp3", 64'(cp3), p1start ? 64'd1 : 64'd2);
        chk("rel_state5", 64'(gs5), 64'd1);
        chk("rel_cp5", 64'(cp5), p1start ? 64'd1 : 64'd2);
        model_init();
    endtask

    task automatic do_move(input int idx);
        bit valid = (idx < mN * mN) && (mb[idx] == 2'b00);
        set_write(1'b1, idx);
        tick();
        set_write(1'b0, 0);
        chk("accept", o_acc(), 64'(valid));
        chk("reject", o_rej(), 64'(!valid));
        if (valid) begin
            mb[idx] = mp;
            mmoves++;
            chk("board_wr", o_board(), exp_board());
            chk("in_check", o_state(), 64'd2);
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("check_hold", o_state(), 64'd2);
            end
            tick();
            if (has_line(mp)) begin
                m_exp_state = 3; m_exp_win = mp; mdone = 1'b1;
            end else if (mmoves == mN * mN) begin
                m_exp_state = 4; m_exp_win = 2'b00; mdone = 1'b1;
            end else begin
                m_exp_state = 1; m_exp_win = 2'b00;
                mp = (mp == 2'b01) ? 2'b10 : 2'b01;
            end
            chk("decide_state", o_state(), 64'(m_exp_state));
            chk("decide_winner", o_win(), 64'(m_exp_win));
            chk("decide_done", o_done(), 64'(mdone));
            if (!mdone) chk("next_player", o_cp(), 64'(mp));
        end else begin
            chk("rej_state", o_state(), 64'd1);
            chk("rej_board", o_board(), exp_board());
        end
    endtask

    task automatic play(input int moves []);
        foreach (moves[i]) do_move(moves[i]);
    endtask

    task automatic done_hold();
        set_write(1'b1, (sel != 0) ? $urandom_range(0, 24) : $urandom_range(0, 8));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_pulses", {o_acc()[0], o_rej()[0]}, 64'd0);
            chk("hold_state", o_state(), 64'(m_exp_state));
            chk("hold_winner", o_win(), 64'(m_exp_win));
            chk("hold_board", o_board(), exp_board());
        end
        set_write(1'b0, 0);
    endtask

    task automatic new_game();
        set_ng(1'b1);
        tick();
        set_ng(1'b0);
        chk("ng_state", o_state(), 64'd0);
        chk("ng_board", o_board(), 64'd0);
        chk("ng_misc", {o_cp()[1:0], o_win()[1:0], o_done()[0]}, 64'd0);
        tick();
        model_init();
        chk("ng_wait", o_state(), 64'd1);
        chk("ng_cp", o_cp(), 64'(mp));
    endtask

    task automatic rand_game();
        int tries = 0;
        while (!mdone && tries < 600) begin
            do_move((sel != 0) ? $urandom_range(0, 31) : $urandom_range(0, 15));
            tries++;
        end
        chk("game_bound", 64'(mdone), 64'd1);
    endtask

    initial begin
        logic [63:0] b;
        sel = 0; mN = 3; mK = 3;
        reset_all(1'b0);
        do_move(4);
        b = o_board();
        chk("cell4", 64'(b[9:8]), 64'd2);
        do_move(4);
        do_move(9);
        set_ng(1'b1);
        tick();
        set_ng(1'b0);
        chk("ng_ignored", o_state(), 64'd1);
        chk("ng_ign_board", o_board(), exp_board());
        set_write(1'b1, 0);
        tick();
        set_write(1'b0, 0);
        chk("pre_rst_acc", o_acc(), 64'd1);
        tick();
        reset_all(1'b1);

        play('{0, 3, 1, 4, 2});
        chk("row_win", 64'(m_exp_state), 64'd3);
        done_hold();
        new_game();
        play('{0, 1, 2, 4, 3, 5, 7, 6, 8});
        chk("draw", o_state(), 64'd4);
        done_hold();
        new_game();
        play('{1, 0, 2, 4, 3, 6, 5, 7, 8});
        chk("ninth_win", o_state(), 64'd3);
        new_game();
        for (int g = 0; g < 8; g++) begin
            rand_game();
            isP1 = 1'($urandom_range(0, 1));
            new_game();
        end

        sel = 1; mN = 5; mK = 4;
        reset_all(1'b1);
        play('{3, 0, 7, 1, 11, 20, 15});
        chk("anti_win", o_state(), 64'd3);
        new_game();
        play('{3, 10, 4, 12, 5, 14, 6});
        chk("wrap_nowin", o_state(), 64'd1);
        reset_all(1'b0);
        for (int g = 0; g < 5; g++) begin
            rand_game();
            isP1 = 1'($urandom_range(0, 1));
            new_game();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/game_core_nxn.md
GAME_CORE_NXN -- requirements
Module: game_core_nxn

Interface
REQ-001 The module SHALL have parameter N, default 3, meaning board side length; legal range 3..8.
REQ-002 The module SHALL have parameter K, default 3, meaning the in-a-row length that wins; legal range 3..N.
REQ-003 The module SHALL have local width W = $clog2(N*N) for the move index.
REQ-004 ph1  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 isPlayer1Start  input  1  1 = player 1 moves first, 0 = player 2 moves first.
REQ-007 playerWrite  input  1  move-request strobe, one cycle per request.
REQ-008 playerInput  input  W  cell index of the requested move: row*N+col.
REQ-009 newGame  input  1  restart request; honoured only in the done states.
REQ-010 gBoard  output  2*N*N  board; cell i at bits [2i+1:2i]; 00 empty, 01 player 1, 10 player 2; 11 never produced.
REQ-011 gameState  output  3  current FSM state encoding.
REQ-012 gameIsDone  output  1  high in DONE_WIN or DONE_DRAW.
REQ-013 winner  output  2  00 none/draw, 01 player 1, 10 player 2.
REQ-014 currentPlayer  output  2  player to move: 01 or 10; 00 in IDLE.
REQ-015 moveAccept  output  1  one-cycle pulse, move written.
REQ-016 moveReject  output  1  one-cycle pulse, move refused.

Function
REQ-017 FSM states and encodings: IDLE=0, WAIT_MOVE=1, CHECK=2, DONE_WIN=3, DONE_DRAW=4; gameState SHALL equal the encoding.
REQ-018 IDLE SHALL last exactly one cycle, load currentPlayer from isPlayer1Start, then enter WAIT_MOVE.
REQ-019 In WAIT_MOVE, with playerWrite=1, playerInput<N*N and the addressed cell 00: write currentPlayer code into the cell, pulse moveAccept, increment the move counter, latch the index, enter CHECK; all on the same edge.
REQ-020 In WAIT_MOVE, with playerWrite=1 and the index >= N*N or the cell non-empty: pulse moveReject, leave the board unchanged, stay in WAIT_MOVE.
REQ-021 playerWrite SHALL be ignored in every state except WAIT_MOVE; moveAccept and moveReject SHALL never be high together.
REQ-022 CHECK SHALL last exactly 4 cycles, one direction per cycle: horizontal, vertical, diagonal, anti-diagonal.
REQ-023 Each CHECK cycle SHALL count consecutive cells equal to the mover's code through the latched cell, up to K-1 per side, clipped at board edges with no row wrap-around.
REQ-024 A win flag SHALL set when any direction's count is >= K.
REQ-025 On leaving CHECK: win -> DONE_WIN with winner = mover; else move counter == N*N -> DONE_DRAW with winner 00; else toggle currentPlayer and return to WAIT_MOVE.
REQ-026 Win SHALL take priority over draw when the last cell completes a line.
REQ-027 Decision latency: accepted move at edge T SHALL give the next state at edge T+4; gameIsDone SHALL be high from edge T+4.
REQ-028 DONE states SHALL be sticky: board, winner and gameIsDone held.
REQ-029 newGame=1 in a DONE state SHALL clear the board, counter and winner and enter IDLE; newGame SHALL be ignored in other states.

Reset
REQ-030 With reset_n=0 at a ph1 edge, on that edge: gBoard all zero, gameState=IDLE, gameIsDone=0, winner=00, currentPlayer=00, moveAccept=0, moveReject=0, move counter 0.
REQ-031 Reset SHALL override all inputs, including mid-CHECK and DONE states.

Verification
REQ-032 Reset, N=3, isPlayer1Start=0 -> all outputs at reset values; two cycles after release, gameState=1 and currentPlayer=10.
REQ-033 Move to index 4, then a second move to index 4 -> first moveAccept with gBoard[9:8]=10; second moveReject with the board unchanged.
REQ-034 N=3, playerInput=9 -> moveReject; gameState stays 1.
REQ-035 N=3, player 1 takes 0, 1, 2 with player 2 taking 3, 4 -> gameState=3, winner=01, gameIsDone 4 cycles after the last accept; newGame -> board zero, gameState=0.
REQ-036 N=3 full board, no line -> gameState=4, winner=00; with a line completed on the ninth move -> DONE_WIN.
REQ-037 N=5, K=4, anti-diagonal win at 3, 7, 11, 15 -> win; 4-in-row wrapping over 3, 4, 5, 6 -> no win.
